config_loader: RTL

Byte-stream configuration loader for the fabric. It accepts framed configuration bytes on a valid/ready interface, validates the frame length and checksum, and shifts the payload bit-serially into the fabric's configuration chain (logic tile LUT/FF-select bits and switch-box select bits). It issues a one-cycle commit strobe only when the whole frame is good. It is the writer side of the configuration memory that the logic tiles and switch boxes consume.

---
 rtl/config_loader_if.sv | 22 ++
 rtl/config_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/config_loader_if.sv
// Byte-stream and configuration-chain signals between a frame source and the loader.
interface config_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       cfg_bit;
  logic       cfg_shift;
  logic       cfg_commit;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output in_data, in_valid,
    input  in_ready, cfg_bit, cfg_shift, cfg_commit, busy, done, error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, cfg_bit, cfg_shift, cfg_commit, busy, done, error
  );
endinterface

// File: rtl/config_loader.sv
// Frame-validating configuration loader: shifts payload bits LSB-first into the
// fabric chain and commits only when length and checksum are both good.
module config_loader #(
  parameter int         CHAIN_BYTES = 117,
  parameter logic [7:0] SYNC        = 8'hA5
) (
  input logic            clock,
  input logic            reset,
  config_loader_if.slave bus
);
  localparam int CW = $clog2(CHAIN_BYTES + 1);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, LOAD, SHIFT, CKSUM, COMMIT} state_t;

  state_t         state, nxt;
  logic [7:0]     len_msb, shreg, sum, sum_nxt;
  logic [CW-1:0]  cnt;
  logic [2:0]     bitn;
  logic           rdy, shift, commit, acc, len_ok, cksum_ok;
  logic           done, error;

  assign sum_nxt  = sum + bus.in_data;
  assign len_ok   = {len_msb, bus.in_data} == 16'(CHAIN_BYTES);
  assign cksum_ok = sum_nxt == 8'h00;
  assign acc      = rdy & bus.in_valid;

  // Reset gates every strobe so a frame cut short by reset leaves no trace.
  always_comb begin
    rdy    = 1'b0;
    shift  = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE, LEN_HI, LEN_LO, LOAD, CKSUM: rdy = 1'b1;
      SHIFT:                             shift = 1'b1;
      COMMIT:                            commit = 1'b1;
      default: ;
    endcase
    if (reset) begin
      rdy    = 1'b0;
      shift  = 1'b0;
      commit = 1'b0;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (acc && bus.in_data == SYNC) nxt = LEN_HI;
      LEN_HI: if (acc) nxt = LEN_LO;
      LEN_LO: if (acc) nxt = len_ok ? LOAD : IDLE;
      LOAD:   if (acc) nxt = SHIFT;
      SHIFT:  if (bitn == 3'd7) nxt = (cnt == CW'(CHAIN_BYTES)) ? CKSUM : LOAD;
      CKSUM:  if (acc) nxt = cksum_ok ? COMMIT : IDLE;
      COMMIT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      len_msb <= '0;
      shreg   <= '0;
      sum     <= '0;
      cnt     <= '0;
      bitn    <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (acc && bus.in_data == SYNC) begin
          done  <= 1'b0;
          error <= 1'b0;
        end
        LEN_HI: if (acc) len_msb <= bus.in_data;
        LEN_LO: if (acc) begin
          if (len_ok) begin
            cnt <= '0;
            sum <= '0;
          end else begin
            error <= 1'b1;
          end
        end
        LOAD: if (acc) begin
          shreg <= bus.in_data;
          sum   <= sum_nxt;
          cnt   <= cnt + CW'(1);
          bitn  <= '0;
        end
        SHIFT: begin
          shreg <= shreg >> 1;
          bitn  <= bitn + 3'd1;
        end
        CKSUM:  if (acc && !cksum_ok) error <= 1'b1;
        COMMIT: done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.cfg_shift  = shift;
  assign bus.cfg_bit    = shift & shreg[0];
  assign bus.cfg_commit = commit;
  assign bus.busy       = (state != IDLE) & ~reset;
  assign bus.done       = done;
  assign bus.error      = error;
endmodule
